// File: rtl/pq_bcd_display_if.sv
// Heading-result / display bundle between the heading block, pq_bcd_display and the board pins.
interface pq_bcd_display_if;
  logic [2:0] state;
  logic [6:0] dataP;
  logic [6:0] dataQ;
  logic       busy;
  logic [6:0] seg;
  logic [5:0] an;

  modport master (output state, dataP, dataQ, input busy, seg, an);
  modport slave  (input state, dataP, dataQ, output busy, seg, an);
endinterface

// File: rtl/pq_bcd_display.sv
// Captures heading P/Q results, converts each to 3 BCD digits by sequential double dabble,
// and scans them onto a 6-digit multiplexed active-low 7-segment display.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for entry into DONE_STATE; display holds last result
// S_LOAD   | operands latched on the start edge; BCD shift regs cleared
// S_CONV_P | 7 double-dabble steps on P
// S_CONV_Q | 7 double-dabble steps on Q
// S_UPDATE | copy both BCD results into the display digit regs at once
module pq_bcd_display #(
  parameter logic [2:0]  DONE_STATE = 3'b100,
  parameter logic [15:0] SCAN_DIV   = 16'd50000
) (
  input logic             clk,
  input logic             rst,
  pq_bcd_display_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CONV_P = 3'd2,
    S_CONV_Q = 3'd3,
    S_UPDATE = 3'd4
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [2:0]  hstate_q, hstate_d;
  logic [6:0]  bin_p_q, bin_p_d;
  logic [6:0]  bin_q_q, bin_q_d;
  logic [9:0]  bcd_p_q, bcd_p_d;
  logic [9:0]  bcd_q_q, bcd_q_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  disp_p_q, disp_p_d;
  logic [9:0]  disp_q_q, disp_q_d;
  logic        busy_q, busy_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [5:0]  an_q, an_d;

  logic        start;
  logic [8:0]  adj_p, adj_q;
  logic [3:0]  dig;
  logic        blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Hundreds never exceeds 1 for a 7-bit operand, so its top bit is always shifted out as 0.
  always_comb begin
    adj_p = {bcd_p_q[8], add3(bcd_p_q[7:4]), add3(bcd_p_q[3:0])};
    adj_q = {bcd_q_q[8], add3(bcd_q_q[7:4]), add3(bcd_q_q[3:0])};
  end

  always_comb begin
    start     = (bus.state == DONE_STATE) && (hstate_q != DONE_STATE);
    hstate_d  = bus.state;
    fsm_d     = fsm_q;
    bin_p_d   = bin_p_q;
    bin_q_d   = bin_q_q;
    bcd_p_d   = bcd_p_q;
    bcd_q_d   = bcd_q_q;
    bit_cnt_d = bit_cnt_q;
    disp_p_d  = disp_p_q;
    disp_q_d  = disp_q_q;

    if (start) begin
      // Restart from any state: latest result wins, old conversion is dropped.
      fsm_d   = S_LOAD;
      bin_p_d = bus.dataP;
      bin_q_d = bus.dataQ;
    end else begin
      case (fsm_q)
        S_IDLE: ;
        S_LOAD: begin
          bcd_p_d   = '0;
          bcd_q_d   = '0;
          bit_cnt_d = 3'd6;
          fsm_d     = S_CONV_P;
        end
        S_CONV_P: begin
          bcd_p_d = {adj_p, bin_p_q[6]};
          bin_p_d = {bin_p_q[5:0], 1'b0};
          if (bit_cnt_q == 3'd0) begin
            bit_cnt_d = 3'd6;
            fsm_d     = S_CONV_Q;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        S_CONV_Q: begin
          bcd_q_d = {adj_q, bin_q_q[6]};
          bin_q_d = {bin_q_q[5:0], 1'b0};
          if (bit_cnt_q == 3'd0) begin
            fsm_d = S_UPDATE;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        S_UPDATE: begin
          disp_p_d = bcd_p_q;
          disp_q_d = bcd_q_q;
          fsm_d    = S_IDLE;
        end
        default: fsm_d = S_IDLE;
      endcase
    end

    busy_d = (fsm_d != S_IDLE);
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    idx_d      = idx_q;
    if (scan_cnt_q >= SCAN_DIV - 16'd1) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_comb begin
    dig   = 4'd0;
    blank = 1'b0;
    case (idx_q)
      3'd0: begin
        dig   = {2'b00, disp_p_q[9:8]};
        blank = (disp_p_q[9:8] == 2'd0);
      end
      3'd1: begin
        dig   = disp_p_q[7:4];
        blank = (disp_p_q[9:8] == 2'd0) && (disp_p_q[7:4] == 4'd0);
      end
      3'd2: dig = disp_p_q[3:0];
      3'd3: begin
        dig   = {2'b00, disp_q_q[9:8]};
        blank = (disp_q_q[9:8] == 2'd0);
      end
      3'd4: begin
        dig   = disp_q_q[7:4];
        blank = (disp_q_q[9:8] == 2'd0) && (disp_q_q[7:4] == 4'd0);
      end
      3'd5: dig = disp_q_q[3:0];
      default: blank = 1'b1;
    endcase
    seg_d = blank ? 7'h7F : seg_decode(dig);
    an_d  = ~(6'b000001 << idx_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= S_IDLE;
      hstate_q   <= 3'b000;
      bin_p_q    <= '0;
      bin_q_q    <= '0;
      bcd_p_q    <= '0;
      bcd_q_q    <= '0;
      bit_cnt_q  <= '0;
      disp_p_q   <= '0;
      disp_q_q   <= '0;
      busy_q     <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= 7'h7F;
      an_q       <= 6'h3F;
    end else begin
      fsm_q      <= fsm_d;
      hstate_q   <= hstate_d;
      bin_p_q    <= bin_p_d;
      bin_q_q    <= bin_q_d;
      bcd_p_q    <= bcd_p_d;
      bcd_q_q    <= bcd_q_d;
      bit_cnt_q  <= bit_cnt_d;
      disp_p_q   <= disp_p_d;
      disp_q_q   <= disp_q_d;
      busy_q     <= busy_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.seg  = seg_q;
  assign bus.an   = an_q;

endmodule
